// File: rtl/sprite_layer_if.sv
// Bus between the scan/control side and sprite_layer: pixel stream, position write port,
// relocation handshake, hit/address result and the relocation FSM state for observation.
interface sprite_layer_if #(
    parameter int ADDR_W = 12
);
    logic [10:0]       pixel_x;
    logic [9:0]        pixel_y;
    logic              wr_en;
    logic [2:0]        wr_idx;
    logic [10:0]       wr_x;
    logic [9:0]        wr_y;
    logic              wr_vis;
    // reloc_req is a one-cycle request sampled only while reloc_busy is low; reloc_ack pulses
    // for exactly one cycle when the new position is written, after which reloc_busy drops.
    logic              reloc_req;
    logic [2:0]        reloc_idx;
    logic              reloc_busy;
    logic              reloc_ack;
    logic              hit;
    logic [2:0]        hit_idx;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        dbg_state;

    modport master (
        output pixel_x, pixel_y, wr_en, wr_idx, wr_x, wr_y, wr_vis, reloc_req, reloc_idx,
        input  reloc_busy, reloc_ack, hit, hit_idx, addr, dbg_state
    );

    modport slave (
        input  pixel_x, pixel_y, wr_en, wr_idx, wr_x, wr_y, wr_vis, reloc_req, reloc_idx,
        output reloc_busy, reloc_ack, hit, hit_idx, addr, dbg_state
    );
endinterface

// File: rtl/sprite_layer.sv
// Multi-sprite hit test and ROM address generator with a 2-stage pipeline.
// Define SPRITE_RELOCATE_EN to build the LFSR-driven random relocation engine.
module sprite_layer #(
    parameter int N_SPRITES = 4,
    parameter int SIZE      = 25,
    parameter int X_MAX     = 799,
    parameter int Y_MAX     = 599,
    parameter int ADDR_W    = 12
) (
    input logic           clk,
    input logic           reset,
    sprite_layer_if.slave bus
);
    localparam int SQ = SIZE * SIZE;

    logic [10:0]          pos_x_q [N_SPRITES];
    logic [9:0]           pos_y_q [N_SPRITES];
    logic [N_SPRITES-1:0] vis_q;

    logic                 commit_en;
    logic [2:0]           commit_idx;
    logic [10:0]          commit_x;
    logic [9:0]           commit_y;

    // A port write in the same cycle as a relocation commit overrides it (later assignment wins).
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_SPRITES; i++) begin
                pos_x_q[i] <= '0;
                pos_y_q[i] <= '0;
            end
            vis_q <= '0;
        end else begin
            for (int i = 0; i < N_SPRITES; i++) begin
                if (commit_en && commit_idx == 3'(i)) begin
                    pos_x_q[i] <= commit_x;
                    pos_y_q[i] <= commit_y;
                    vis_q[i]   <= 1'b1;
                end
                if (bus.wr_en && bus.wr_idx == 3'(i)) begin
                    pos_x_q[i] <= bus.wr_x;
                    pos_y_q[i] <= bus.wr_y;
                    vis_q[i]   <= bus.wr_vis;
                end
            end
        end
    end

    logic [N_SPRITES-1:0] hit1_d, hit1_q;
    logic [10:0]          dx1_d [N_SPRITES];
    logic [10:0]          dx1_q [N_SPRITES];
    logic [9:0]           dy1_d [N_SPRITES];
    logic [9:0]           dy1_q [N_SPRITES];

    // Bounds are compared one bit wider so pos + SIZE cannot wrap near the top of the range.
    always_comb begin
        hit1_d = '0;
        for (int i = 0; i < N_SPRITES; i++) begin
            hit1_d[i] = vis_q[i]
                && ({1'b0, bus.pixel_x} >= {1'b0, pos_x_q[i]})
                && ({1'b0, bus.pixel_x} <  {1'b0, pos_x_q[i]} + 12'(SIZE))
                && ({1'b0, bus.pixel_y} >= {1'b0, pos_y_q[i]})
                && ({1'b0, bus.pixel_y} <  {1'b0, pos_y_q[i]} + 11'(SIZE));
            dx1_d[i] = bus.pixel_x - pos_x_q[i];
            dy1_d[i] = bus.pixel_y - pos_y_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit1_q <= '0;
            for (int i = 0; i < N_SPRITES; i++) begin
                dx1_q[i] <= '0;
                dy1_q[i] <= '0;
            end
        end else begin
            hit1_q <= hit1_d;
            for (int i = 0; i < N_SPRITES; i++) begin
                dx1_q[i] <= dx1_d[i];
                dy1_q[i] <= dy1_d[i];
            end
        end
    end

    logic              hit_d, hit_q;
    logic [2:0]        hit_idx_d, hit_idx_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [10:0]       sel_dx;
    logic [9:0]        sel_dy;

    // Scanning from the top index down leaves the lowest hitting index selected.
    always_comb begin
        hit_d     = 1'b0;
        hit_idx_d = '0;
        sel_dx    = '0;
        sel_dy    = '0;
        for (int i = N_SPRITES - 1; i >= 0; i--) begin
            if (hit1_q[i]) begin
                hit_d     = 1'b1;
                hit_idx_d = 3'(i);
                sel_dx    = dx1_q[i];
                sel_dy    = dy1_q[i];
            end
        end
        addr_d = '0;
        if (hit_d) begin
            addr_d = ADDR_W'(int'(hit_idx_d) * SQ + int'(sel_dy) * SIZE + int'(sel_dx));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_q     <= 1'b0;
            hit_idx_q <= '0;
            addr_q    <= '0;
        end else begin
            hit_q     <= hit_d;
            hit_idx_q <= hit_idx_d;
            addr_q    <= addr_d;
        end
    end

    assign bus.hit     = hit_q;
    assign bus.hit_idx = hit_idx_q;
    assign bus.addr    = addr_q;

`ifdef SPRITE_RELOCATE_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAW   = 2'd1,
        COMMIT = 2'd2
    } reloc_state_e;

    reloc_state_e state_q, state_d;
    logic [15:0]  lfsr_q;
    logic [2:0]   ridx_q, ridx_d;
    logic [10:0]  cand_x_q, cand_x_d;
    logic [9:0]   cand_y_q, cand_y_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            lfsr_q   <= 16'hACE1;
            ridx_q   <= '0;
            cand_x_q <= '0;
            cand_y_q <= '0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            ridx_q   <= ridx_d;
            cand_x_q <= cand_x_d;
            cand_y_q <= cand_y_d;
        end
    end

    // An out-of-range draw just stays in DRAW: the LFSR has moved on by the next cycle.
    always_comb begin
        state_d        = state_q;
        ridx_d         = ridx_q;
        cand_x_d       = cand_x_q;
        cand_y_d       = cand_y_q;
        bus.reloc_busy = 1'b1;
        bus.reloc_ack  = 1'b0;
        commit_en      = 1'b0;
        case (state_q)
            IDLE: begin
                bus.reloc_busy = 1'b0;
                if (bus.reloc_req && int'(bus.reloc_idx) < N_SPRITES) begin
                    ridx_d  = bus.reloc_idx;
                    state_d = DRAW;
                end
            end
            DRAW: begin
                cand_x_d = lfsr_q[10:0];
                cand_y_d = lfsr_q[15:6];
                if (int'(lfsr_q[10:0]) <= X_MAX - SIZE + 1 && int'(lfsr_q[15:6]) <= Y_MAX - SIZE + 1) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                bus.reloc_ack = 1'b1;
                commit_en     = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign commit_idx    = ridx_q;
    assign commit_x      = cand_x_q;
    assign commit_y      = cand_y_q;
    assign bus.dbg_state = state_q;
`else
    logic unused_reloc;
    assign unused_reloc   = ^{bus.reloc_req, bus.reloc_idx};
    assign commit_en      = 1'b0;
    assign commit_idx     = '0;
    assign commit_x       = '0;
    assign commit_y       = '0;
    assign bus.reloc_busy = 1'b0;
    assign bus.reloc_ack  = 1'b0;
    assign bus.dbg_state  = '0;
`endif
endmodule

// File: tb/tb_sprite_layer.sv
// Directed bench for sprite_layer: hit/priority/address vectors, reset flush, frame scan,
// and the relocation handshake (or its absence when SPRITE_RELOCATE_EN is undefined).
module tb_sprite_layer;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    sprite_layer_if #(.ADDR_W(12)) bus ();

    sprite_layer #(
        .N_SPRITES(4), .SIZE(25), .X_MAX(799), .Y_MAX(599), .ADDR_W(12)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic write_sprite(input logic [2:0] idx, input logic [10:0] x,
                                input logic [9:0] y, input logic v);
        bus.wr_en  = 1'b1;
        bus.wr_idx = idx;
        bus.wr_x   = x;
        bus.wr_y   = y;
        bus.wr_vis = v;
        tick();
        bus.wr_en  = 1'b0;
    endtask

    task automatic check_pixel(input string tag, input logic [10:0] x, input logic [9:0] y,
                               input logic eh, input logic [2:0] ei, input logic [11:0] ea);
        bus.pixel_x = x;
        bus.pixel_y = y;
        tick();
        tick();
        check({tag, "_hit"}, 32'(bus.hit), 32'(eh));
        check({tag, "_idx"}, 32'(bus.hit_idx), 32'(ei));
        check({tag, "_addr"}, 32'(bus.addr), 32'(ea));
    endtask

    initial begin
        int hits_seen;
        int acks_seen;
        int busy_seen;
        n_checks      = 0;
        n_errors      = 0;
        reset         = 1'b1;
        bus.pixel_x   = '0;
        bus.pixel_y   = '0;
        bus.wr_en     = 1'b0;
        bus.wr_idx    = '0;
        bus.wr_x      = '0;
        bus.wr_y      = '0;
        bus.wr_vis    = 1'b0;
        bus.reloc_req = 1'b0;
        bus.reloc_idx = '0;
        do_reset();

        check("rst_hit", 32'(bus.hit), 0);
        check("rst_idx", 32'(bus.hit_idx), 0);
        check("rst_addr", 32'(bus.addr), 0);
        check("rst_busy", 32'(bus.reloc_busy), 0);
        check("rst_ack", 32'(bus.reloc_ack), 0);

        // Single sprite: corners and just-outside edges.
        write_sprite(3'd0, 11'd600, 10'd300, 1'b1);
        check_pixel("s0_tl", 11'd600, 10'd300, 1'b1, 3'd0, 12'd0);
        check_pixel("s0_br", 11'd624, 10'd324, 1'b1, 3'd0, 12'd624);
        check_pixel("s0_right", 11'd625, 10'd300, 1'b0, 3'd0, 12'd0);
        check_pixel("s0_below", 11'd600, 10'd325, 1'b0, 3'd0, 12'd0);
        check_pixel("s0_left", 11'd599, 10'd300, 1'b0, 3'd0, 12'd0);

        // Overlap: lowest index wins, then sprite 1 once sprite 0 is hidden.
        write_sprite(3'd1, 11'd610, 10'd300, 1'b1);
        check_pixel("ovl_s0", 11'd612, 10'd301, 1'b1, 3'd0, 12'd37);
        write_sprite(3'd0, 11'd600, 10'd300, 1'b0);
        check_pixel("ovl_s1", 11'd612, 10'd301, 1'b1, 3'd1, 12'd652);

        // Out-of-range index is dropped.
        write_sprite(3'd4, 11'd100, 10'd100, 1'b1);
        check_pixel("bad_idx", 11'd100, 10'd100, 1'b0, 3'd0, 12'd0);

        write_sprite(3'd3, 11'd0, 10'd0, 1'b1);
        check_pixel("s3_org", 11'd0, 10'd0, 1'b1, 3'd3, 12'd1875);
        check_pixel("s3_far", 11'd24, 10'd24, 1'b1, 3'd3, 12'd2499);
        write_sprite(3'd2, 11'd0, 10'd0, 1'b1);
        check_pixel("s2_over_s3", 11'd0, 10'd0, 1'b1, 3'd2, 12'd1250);

        // Reset with a hit in flight must flush both pipeline stages.
        bus.pixel_x = 11'd0;
        bus.pixel_y = 10'd0;
        tick();
        reset = 1'b1;
        tick();
        check("flush_s2", 32'(bus.hit), 0);
        reset = 1'b0;
        tick();
        check("flush_s1", 32'(bus.hit), 0);

        // Coarse frame scan: every sprite is invisible after reset.
        hits_seen = 0;
        for (int y = 0; y < 600; y += 8) begin
            for (int x = 0; x < 800; x += 8) begin
                bus.pixel_x = 11'(x);
                bus.pixel_y = 10'(y);
                tick();
                if (bus.hit) hits_seen++;
            end
        end
        check("frame_hits", 32'(hits_seen), 0);

`ifdef SPRITE_RELOCATE_EN
        do_reset();
        bus.reloc_req = 1'b1;
        bus.reloc_idx = 3'd2;
        tick();
        bus.reloc_req = 1'b0;
        check("reloc_busy_next", 32'(bus.reloc_busy), 1);
        check("reloc_no_early_ack", 32'(bus.reloc_ack), 0);
        for (int n = 0; n < 64 && !bus.reloc_ack; n++) begin
            if (n == 0) begin
                bus.reloc_req = 1'b1;
                bus.reloc_idx = 3'd1;
            end
            tick();
            bus.reloc_req = 1'b0;
        end
        check("reloc_ack_seen", 32'(bus.reloc_ack), 1);
        acks_seen = 0;
        for (int n = 0; n < 64; n++) begin
            tick();
            if (bus.reloc_ack) acks_seen++;
        end
        check("reloc_second_ack", 32'(acks_seen), 0);
        check("reloc_idle", 32'(bus.reloc_busy), 0);
        check("reloc_x_bound", 32'(dut.pos_x_q[2] <= 11'd775), 1);
        check("reloc_y_bound", 32'(dut.pos_y_q[2] <= 10'd575), 1);
        check("reloc_vis", 32'(dut.vis_q[2]), 1);
        check("reloc_s1_untouched", 32'(dut.vis_q[1]), 0);
        check_pixel("reloc_pix", dut.pos_x_q[2], dut.pos_y_q[2], 1'b1, 3'd2, 12'd1250);

        // Port write lands in the commit cycle and overrides the random position.
        bus.reloc_req = 1'b1;
        bus.reloc_idx = 3'd2;
        tick();
        bus.reloc_req = 1'b0;
        for (int n = 0; n < 64 && bus.dbg_state != 2'd2; n++) tick();
        check("commit_reached", 32'(bus.dbg_state), 2);
        check("commit_ack", 32'(bus.reloc_ack), 1);
        write_sprite(3'd2, 11'd50, 10'd60, 1'b1);
        check_pixel("commit_wr_tl", 11'd50, 10'd60, 1'b1, 3'd2, 12'd1250);
        check_pixel("commit_wr_br", 11'd74, 10'd84, 1'b1, 3'd2, 12'd1874);
        check_pixel("commit_wr_out", 11'd49, 10'd60, 1'b0, 3'd0, 12'd0);

        // Reset while drawing abandons the relocation silently.
        bus.reloc_req = 1'b1;
        bus.reloc_idx = 3'd3;
        tick();
        bus.reloc_req = 1'b0;
        check("draw_busy", 32'(bus.reloc_busy), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_draw_busy", 32'(bus.reloc_busy), 0);
        check("rst_draw_ack", 32'(bus.reloc_ack), 0);
        acks_seen = 0;
        for (int n = 0; n < 16; n++) begin
            tick();
            if (bus.reloc_ack) acks_seen++;
        end
        check("rst_draw_no_ack", 32'(acks_seen), 0);
        check("rst_draw_vis", 32'(dut.vis_q), 0);
`else
        do_reset();
        bus.reloc_req = 1'b1;
        bus.reloc_idx = 3'd2;
        tick();
        bus.reloc_req = 1'b0;
        acks_seen = 0;
        busy_seen = 0;
        for (int n = 0; n < 64; n++) begin
            if (bus.reloc_ack) acks_seen++;
            if (bus.reloc_busy) busy_seen++;
            tick();
        end
        check("noreloc_ack", 32'(acks_seen), 0);
        check("noreloc_busy", 32'(busy_seen), 0);
        check_pixel("noreloc_pix", 11'd0, 10'd0, 1'b0, 3'd0, 12'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
